sym_ram_dp: RTL and testbench



---
 rtl/sym_ram_pkg.sv | 6 +
 rtl/sym_ram_clr_seq.sv | 36 +++
 rtl/sym_ram_dp.sv | 67 ++++++
 tb/tb_sym_ram_dp.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/sym_ram_pkg.sv
// sym_ram_pkg: shared clear-sequencer states and default symbol/address widths
package sym_ram_pkg;
  localparam int SYM_DW = 16;
  localparam int SYM_AW = 5;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
endpackage

// File: rtl/sym_ram_clr_seq.sv
// sym_ram_clr_seq: zeroes the array one word per edge after reset or on clr_start_i
module sym_ram_clr_seq
  import sym_ram_pkg::*;
#(
  parameter int AW    = SYM_AW,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start_i,
  output logic          clr_busy_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          last;
  always_comb begin
    last    = cnt_q == LAST;
    state_d = (state_q == ST_CLEAR) ? (last ? ST_IDLE : ST_CLEAR) : (clr_start_i ? ST_CLEAR : ST_IDLE);
    cnt_d   = (state_q == ST_CLEAR && !last) ? cnt_q + 1'b1 : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign clr_busy_o = state_q == ST_CLEAR;
  assign clr_we_o   = state_q == ST_CLEAR;
  assign clr_addr_o = cnt_q;
endmodule

// File: rtl/sym_ram_dp.sv
// sym_ram_dp: simple-dual-port symbol RAM with registered read and hardware clear.
// SYM_RAM_BYPASS_EN selects write-first forwarding on same-address read/write.
module sym_ram_dp
  import sym_ram_pkg::*;
#(
  parameter int DW    = SYM_DW,
  parameter int AW    = SYM_AW,
  parameter int DEPTH = 1 << AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_start,
  output logic          clr_busy,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic          ren,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout,
  output logic          dout_vld
);
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          we, win, rin, hit;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd, rdata;
  logic [DW-1:0] dout_q, dout_d;
  logic          vld_q, vld_d;
  logic [DW-1:0] mem_q [0:DEPTH-1];
  sym_ram_clr_seq #(.AW(AW), .DEPTH(DEPTH)) u_clr (
    .clk        (clk),
    .rst        (rst),
    .clr_start_i(clr_start),
    .clr_busy_o (clr_busy),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );
  always_comb begin
    win    = {1'b0, waddr} < (AW+1)'(DEPTH);
    rin    = {1'b0, raddr} < (AW+1)'(DEPTH);
    we     = clr_busy ? clr_we : (wen && win);
    wa     = clr_busy ? clr_addr : waddr;
    wd     = clr_busy ? '0 : din;
`ifdef SYM_RAM_BYPASS_EN
    hit    = wen && waddr == raddr;
`else
    hit    = 1'b0;
`endif
    rdata  = !rin ? '0 : (hit ? din : mem_q[raddr]);
    vld_d  = !clr_busy && ren;
    dout_d = vld_d ? rdata : dout_q;
  end
  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end
  assign dout     = dout_q;
  assign dout_vld = vld_q;
endmodule

// File: tb/tb_sym_ram_dp.sv
// tb_sym_ram_dp: directed vectors with a read-data scoreboard checked by a separate monitor
module tb_sym_ram_dp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        wen = 1'b0;
  logic [4:0]  waddr = '0;
  logic [15:0] din = '0;
  logic        ren = 1'b0;
  logic [4:0]  raddr = '0;
  logic [15:0] dout;
  logic        dout_vld;
  int          vec = 0;
  int          err = 0;
  logic [15:0] exp_q[$];

  sym_ram_dp #(.DW(16), .AW(5), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy),
    .wen(wen), .waddr(waddr), .din(din), .ren(ren), .raddr(raddr),
    .dout(dout), .dout_vld(dout_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && dout_vld) begin
      if (exp_q.size() == 0) chk("unexpected_vld", 32'd1, 32'd0);
      else chk("dout", {16'h0, dout}, {16'h0, exp_q.pop_front()});
    end
  end

  task automatic rd(input logic [4:0] a, input logic [15:0] e);
    ren = 1'b1;
    raddr = a;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    wen = 1'b0;
    ren = 1'b0;
    clr_start = 1'b0;
  endtask

  task automatic wait_clear(input string name, input bit poke);
    int n = 0;
    while (clr_busy && n < 100) begin
      if (poke) begin
        wen = 1'b1;
        waddr = 5'(31 - n);
        din = 16'hFFFF;
        ren = 1'b1;
        raddr = 5'(n);
        clr_start = (n == 10);
      end
      step();
      n++;
      chk("vld_in_clear", {31'h0, dout_vld}, 32'd0);
    end
    idle();
    chk(name, n, 32);
  endtask

  task automatic read_all_zero();
    for (int a = 0; a < 32; a++) begin
      rd(5'(a), 16'h0000);
      step();
    end
    idle();
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    step();
    chk("rst_busy", {31'h0, clr_busy}, 32'd1);
    chk("rst_dout", {16'h0, dout}, 32'h0);
    chk("rst_vld", {31'h0, dout_vld}, 32'd0);
    rst = 1'b0;
    wait_clear("busy_after_rst", 1'b0);
    read_all_zero();

    wen = 1'b1; waddr = 5'd3; din = 16'hA5A5;
    step();
    wen = 1'b0;
    rd(5'd3, 16'hA5A5);
    step();
    idle();
    step();
    chk("vld_drop", {31'h0, dout_vld}, 32'd0);
    chk("dout_hold", {16'h0, dout}, 32'hA5A5);

    wen = 1'b1; waddr = 5'd7; din = 16'h1111;
    step();
    din = 16'h2222;
`ifdef SYM_RAM_BYPASS_EN
    rd(5'd7, 16'h2222);
`else
    rd(5'd7, 16'h1111);
`endif
    step();
    wen = 1'b0;
    rd(5'd7, 16'h2222);
    step();
    idle();
    step();

    for (int a = 0; a < 32; a++) begin
      wen = 1'b1; waddr = 5'(a); din = 16'h8000 | 16'(a);
      step();
    end
    wen = 1'b0;
    rd(5'd9, 16'h8009);
    step();
    idle();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    chk("busy_rise", {31'h0, clr_busy}, 32'd1);
    wait_clear("busy_clr_start", 1'b1);
    read_all_zero();

    wen = 1'b1; waddr = 5'd5; din = 16'hBEEF;
    step();
    wen = 1'b0;
    rd(5'd5, 16'hBEEF);
    step();
    idle();
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("dout_before_rst", {16'h0, dout}, 32'hBEEF);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'h0, clr_busy}, 32'd1);
    chk("mid_rst_dout", {16'h0, dout}, 32'h0);
    chk("mid_rst_vld", {31'h0, dout_vld}, 32'd0);
    step();
    rst = 1'b0;
    wait_clear("busy_after_mid_rst", 1'b0);
    rd(5'd5, 16'h0000);
    step();
    idle();
    step();

    for (int n = 0; n <= 32; n++) begin
      wen = n < 32;
      waddr = 5'(n);
      din = 16'h0100 + 16'(n);
      ren = 1'b0;
      if (n > 0) rd(5'(n - 1), 16'h0100 + 16'(n - 1));
      step();
      if (n > 0) chk("ramp_vld", {31'h0, dout_vld}, 32'd1);
    end
    idle();
    step();
    step();
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
